hoene_led_pwm_multi: RTL and testbench



---
 rtl/hoene_led_pwm_multi.sv | 105 ++++++++++
 tb/tb_hoene_led_pwm_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hoene_led_pwm_multi.sv
// ============================================================================
// Module   : hoene_led_pwm_multi
// Brief    : CHANNELS x WIDTH-bit PWM with a shared period counter, optional
//            prescaler and double-buffered duty banks swapped at period wrap.
//            Optional macro PWM_STAGGER_EN spreads channel phases over the period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hoene_led_pwm_multi #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CHANNELS*WIDTH-1:0]    duty_in,
    input  logic                         load,
    output logic [CHANNELS-1:0]          out,
    output logic                         period_start,
    output logic                         pending
);

    localparam int                 c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
`ifdef PWM_STAGGER_EN
    localparam int                 c_OFS     = (1 << WIDTH) / CHANNELS;
`else
    localparam int                 c_OFS     = 0;
`endif

    logic [c_PRE_W-1:0]          r_pre_cnt;
    logic [WIDTH-1:0]            r_cnt;
    logic [CHANNELS*WIDTH-1:0]   r_shadow;
    logic [CHANNELS*WIDTH-1:0]   r_active;
    logic [CHANNELS-1:0]         r_out;
    logic                        r_period_start;
    logic                        r_pending;

    logic                        w_tick;
    logic                        w_wrap;
    logic [CHANNELS-1:0]         w_hi;

    assign w_tick = (r_pre_cnt == c_PRE_MAX);
    assign w_wrap = w_tick && (&r_cnt);

    // Each channel compares against the shared counter shifted by its phase offset.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            localparam logic [WIDTH-1:0] c_CH_OFS = WIDTH'((gi * c_OFS) % (1 << WIDTH));
            logic [WIDTH-1:0] w_cmp;
            assign w_cmp    = r_cnt + c_CH_OFS;
            assign w_hi[gi] = (r_active[gi*WIDTH +: WIDTH] > w_cmp);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_shadow       <= '0;
            r_active       <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
            r_pending      <= 1'b0;
        end else if (!enable) begin
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_out          <= '0;
            r_period_start <= 1'b0;
            r_pending      <= 1'b0;
            // Nothing is being displayed, so a load can go live immediately.
            if (load) begin
                r_shadow <= duty_in;
                r_active <= duty_in;
            end
        end else begin
            r_pre_cnt      <= w_tick ? '0 : r_pre_cnt + c_PRE_W'(1);
            if (w_tick) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            r_out          <= w_hi;
            r_period_start <= w_wrap;
            if (load && w_wrap) begin
                r_active  <= duty_in;
                r_shadow  <= duty_in;
                r_pending <= 1'b0;
            end else if (load) begin
                r_shadow  <= duty_in;
                r_pending <= 1'b1;
            end else if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
    assign pending      = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_hoene_led_pwm_multi.sv
// ============================================================================
// Module   : tb_hoene_led_pwm_multi
// Brief    : Randomized and directed bench for hoene_led_pwm_multi, two
//            instances (PRESCALE 1 and 3) checked against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hoene_led_pwm_multi;

    localparam int c_CH = 3;
    localparam int c_W  = 4;
    localparam int c_P  = 1 << c_W;
`ifdef PWM_STAGGER_EN
    localparam int c_OFS = c_P / c_CH;
`else
    localparam int c_OFS = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable = 1'b0;
    logic                  load = 1'b0;
    logic [c_CH*c_W-1:0]   duty_in = '0;
    logic [c_CH-1:0]       out_a, out_b;
    logic                  ps_a, ps_b, pend_a, pend_b;

    hoene_led_pwm_multi #(.CHANNELS(c_CH), .WIDTH(c_W), .PRESCALE(1)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_in), .load(load),
        .out(out_a), .period_start(ps_a), .pending(pend_a));

    hoene_led_pwm_multi #(.CHANNELS(c_CH), .WIDTH(c_W), .PRESCALE(3)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .duty_in(duty_in), .load(load),
        .out(out_b), .period_start(ps_b), .pending(pend_b));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: enabled clocks since restart, banks, pending.
    int m_run [2];
    int m_sh  [2][c_CH];
    int m_act [2][c_CH];
    int m_pend[2];
    int e_out [2];
    int e_ps  [2];

    int hcnt[c_CH];
    int pscnt;
    int pendcnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int pr;
            pr = (k == 0) ? 1 : 3;
            if (rst) begin
                m_run[k] = 0; m_pend[k] = 0; e_out[k] = 0; e_ps[k] = 0;
                for (int i = 0; i < c_CH; i++) begin m_sh[k][i] = 0; m_act[k][i] = 0; end
            end else if (!enable) begin
                m_run[k] = 0; m_pend[k] = 0; e_out[k] = 0; e_ps[k] = 0;
                if (load)
                    for (int i = 0; i < c_CH; i++) begin
                        m_sh[k][i]  = int'(duty_in[i*c_W +: c_W]);
                        m_act[k][i] = m_sh[k][i];
                    end
            end else begin
                int cnt;
                bit tick, wrap;
                cnt  = (m_run[k] / pr) % c_P;
                tick = ((m_run[k] % pr) == pr - 1);
                wrap = tick && (cnt == c_P - 1);
                e_out[k] = 0;
                for (int i = 0; i < c_CH; i++)
                    if (m_act[k][i] > ((cnt + i * c_OFS) % c_P)) e_out[k] |= (1 << i);
                e_ps[k] = wrap ? 1 : 0;
                if (load) begin
                    for (int i = 0; i < c_CH; i++) begin
                        m_sh[k][i] = int'(duty_in[i*c_W +: c_W]);
                        if (wrap) m_act[k][i] = m_sh[k][i];
                    end
                    m_pend[k] = wrap ? 0 : 1;
                end else if (wrap && m_pend[k] != 0) begin
                    for (int i = 0; i < c_CH; i++) m_act[k][i] = m_sh[k][i];
                    m_pend[k] = 0;
                end
                m_run[k]++;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("out_a",  int'(out_a),  e_out[0]);
        check_eq("ps_a",   int'(ps_a),   e_ps[0]);
        check_eq("pend_a", int'(pend_a), m_pend[0]);
        check_eq("out_b",  int'(out_b),  e_out[1]);
        check_eq("ps_b",   int'(ps_b),   e_ps[1]);
        check_eq("pend_b", int'(pend_b), m_pend[1]);
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2);
        duty_in = {c_W'(d2), c_W'(d1), c_W'(d0)};
    endtask

    task automatic wait_ps(input int k);
        for (int n = 0; n < 200; n++) begin
            cycle();
            if (((k == 0) ? ps_a : ps_b) === 1'b1) return;
        end
        check_eq("wait_ps_timeout", 0, 1);
    endtask

    task automatic count_win(input int k, input int n);
        pscnt = 0; pendcnt = 0;
        for (int i = 0; i < c_CH; i++) hcnt[i] = 0;
        repeat (n) begin
            cycle();
            for (int i = 0; i < c_CH; i++) hcnt[i] += (k == 0) ? int'(out_a[i]) : int'(out_b[i]);
            pscnt   += (k == 0) ? int'(ps_a) : int'(ps_b);
            pendcnt += (k == 0) ? int'(pend_a) : int'(pend_b);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_pend[k] = 0; e_out[k] = 0; e_ps[k] = 0;
            for (int i = 0; i < c_CH; i++) begin m_sh[k][i] = 0; m_act[k][i] = 0; end
        end

        // Reset state
        cycle();
        cycle();
        check_eq("rst_out_a", int'(out_a), 0);
        rst = 1'b0;
        enable = 1'b1;

        // Basic duties 0/8/15
        set_duty(0, 8, 15); load = 1'b1; cycle(); load = 1'b0;
        wait_ps(0);
        count_win(0, 16);
        check_eq("hi_d0", hcnt[0], 0);
        check_eq("hi_d8", hcnt[1], 8);
        check_eq("hi_d15", hcnt[2], 15);
        check_eq("ps_per16", pscnt, 1);
        check_eq("ps_at_end", int'(ps_a), 1);

        // Mid-period load stays pending until the wrap
        repeat (5) cycle();
        set_duty(4, 4, 4); load = 1'b1; cycle(); load = 1'b0;
        check_eq("pend_mid", int'(pend_a), 1);
        wait_ps(0);
        check_eq("pend_after_wrap", int'(pend_a), 0);
        count_win(0, 16);
        check_eq("hi_d4", hcnt[0] + hcnt[1] + hcnt[2], 12);

        // Load coinciding with the wrap takes effect in the next period directly
        repeat (15) cycle();
        set_duty(12, 12, 12); load = 1'b1; cycle(); load = 1'b0;
        check_eq("wrap_load_ps", int'(ps_a), 1);
        check_eq("wrap_load_pend", int'(pend_a), 0);
        count_win(0, 16);
        check_eq("hi_d12", hcnt[1], 12);
        check_eq("wrap_load_pendcnt", pendcnt, 0);

        // Prescaled instance: 48-clock period, duty 8 -> 24 high clocks
        set_duty(8, 8, 8); load = 1'b1; cycle(); load = 1'b0;
        wait_ps(1);
        count_win(1, 48);
        check_eq("pre_ps_per48", pscnt, 1);
        check_eq("pre_ps_end", int'(ps_b), 1);
        check_eq("pre_hi_d8", hcnt[0], 24);

        // Reset mid-period, then a disabled load goes live immediately
        wait_ps(0);
        repeat (9) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("midrst_out", int'(out_a), 0);
        check_eq("midrst_pend", int'(pend_a), 0);
        enable = 1'b0;
        set_duty(5, 5, 5); load = 1'b1; cycle(); load = 1'b0;
        check_eq("dis_out", int'(out_a), 0);
        check_eq("dis_pend", int'(pend_a), 0);
        cycle();
        enable = 1'b1;
        count_win(0, 16);
        check_eq("reen_hi_d5", hcnt[0], 5);
        check_eq("reen_hi_d5_ch2", hcnt[2], 5);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            rst    = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 24) != 0);
            load   = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < c_CH; i++) begin
                int sel;
                sel = $urandom_range(0, 3);
                duty_in[i*c_W +: c_W] = (sel == 0) ? '0 : (sel == 1) ? '1 : c_W'($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
